pcie_pipe_symbol_packer: RTL and testbench

//  Receive-side gearbox for the PIPE-width pcieVHost models. Takes one 8b symbol + K flag per

---
 rtl/pcie_pipe_symbol_packer_pkg.sv | 10 +
 rtl/pcie_pipe_symbol_packer_if.sv | 23 ++
 rtl/pcie_pipe_skid_fifo.sv | 37 +++
 rtl/pcie_pipe_symbol_packer.sv | 95 +++++++++
 tb/tb_pcie_pipe_symbol_packer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/pcie_pipe_symbol_packer_pkg.sv
// pcie_pipe_symbol_packer_pkg: shared symbol constants and aligner state encoding
package pcie_pipe_symbol_packer_pkg;
  localparam logic [7:0] ComK285 = 8'hBC;
  localparam logic [7:0] SkpK280 = 8'h1C;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    ALIGNED = 2'd2
  } alignState_t;
endpackage

// File: rtl/pcie_pipe_symbol_packer_if.sv
// pcie_pipe_symbol_packer_if: lane symbol input and packed word output bundle
interface pcie_pipe_symbol_packer_if #(parameter int DataWidth = 32);
  localparam int NBytes = DataWidth / 8;
  logic [7:0]           SymIn;
  logic                 SymInK;
  logic                 SymInValid;
  logic                 ElecIdle;
  logic [DataWidth-1:0] WordOut;
  logic [NBytes-1:0]    WordOutK;
  logic                 WordOutValid;
  logic                 WordOutReady;
  logic                 Aligned;
  logic                 Realign;
  logic                 Overflow;
  modport master (
    output SymIn, SymInK, SymInValid, ElecIdle, WordOutReady,
    input  WordOut, WordOutK, WordOutValid, Aligned, Realign, Overflow
  );
  modport slave (
    input  SymIn, SymInK, SymInValid, ElecIdle, WordOutReady,
    output WordOut, WordOutK, WordOutValid, Aligned, Realign, Overflow
  );
endinterface

// File: rtl/pcie_pipe_skid_fifo.sv
// pcie_pipe_skid_fifo: 2-entry valid/ready FIFO with registered head and sticky overflow
module pcie_pipe_skid_fifo #(
  parameter int Width = 36
) (
  input  logic             pcieclk,
  input  logic             reset,
  input  logic             pushValid,
  input  logic [Width-1:0] pushData,
  input  logic             popReady,
  output logic [Width-1:0] headData,
  output logic             headValid,
  output logic             overflow
);
  logic [Width-1:0] mem [2];
  logic [1:0] count;
  logic pop, full, accept;
  assign headValid = count != 2'd0;
  assign full      = count == 2'd2;
  assign pop       = headValid & popReady;
  assign accept    = pushValid & (~full | pop);
  assign headData  = mem[0];
  // mem[0] is the head and only moves on a real pop or a push into an empty head slot
  always_ff @(posedge pcieclk) begin
    if (reset) begin
      count    <= 2'd0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count + 2'(accept) - 2'(pop);
      if (pushValid & full & ~pop) overflow <= 1'b1;
      if ((count == 2'd0 & pushValid) | (count == 2'd1 & pop & pushValid)) mem[0] <= pushData;
      else if (count == 2'd2 & pop) mem[0] <= mem[1];
      if ((count == 2'd1 & pushValid & ~pop) | (count == 2'd2 & pop & pushValid)) mem[1] <= pushData;
    end
  end
endmodule

// File: rtl/pcie_pipe_symbol_packer.sv
// pcie_pipe_symbol_packer: COM-aligned gearbox packing x1 lane symbols into PIPE-width words
module pcie_pipe_symbol_packer
  import pcie_pipe_symbol_packer_pkg::*;
#(
  parameter int         DataWidth = 32,
  parameter int         LockCount = 2,
  parameter logic [7:0] ComSymbol = ComK285
) (
  input logic pcieclk,
  input logic reset,
  pcie_pipe_symbol_packer_if.slave bus
);
  localparam int NBytes = DataWidth / 8;
  localparam int IdxW   = $clog2(NBytes);
  alignState_t state;
  logic [IdxW-1:0] idx;
  logic [2:0] misCnt;
  logic [DataWidth-1:0] asmData, nextData;
  logic [NBytes-1:0] asmK, nextK;
  logic [DataWidth+NBytes-1:0] pushWord, headWord;
  logic pushValid, isCom, lastByte, aligned, realign;
  assign isCom    = bus.SymInValid & bus.SymInK & (bus.SymIn == ComSymbol);
  assign lastByte = idx == IdxW'(NBytes - 1);
  always_comb begin
    nextData = asmData;
    nextK    = asmK;
    nextData[{idx, 3'b000} +: 8] = bus.SymIn;
    nextK[idx] = bus.SymInK;
  end
  // pushes are registered here so the FIFO sees a completed word one edge after its last byte
  always_ff @(posedge pcieclk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      misCnt    <= '0;
      asmData   <= '0;
      asmK      <= '0;
      pushValid <= 1'b0;
      pushWord  <= '0;
      aligned   <= 1'b0;
      realign   <= 1'b0;
    end else begin
      pushValid <= 1'b0;
      realign   <= 1'b0;
      if (bus.ElecIdle) begin
        state   <= IDLE;
        idx     <= '0;
        misCnt  <= '0;
        aligned <= 1'b0;
      end else if (state == IDLE) begin
        state <= HUNT;
      end else if (state == HUNT) begin
        if (isCom) begin
          state   <= ALIGNED;
          aligned <= 1'b1;
          asmData <= DataWidth'(ComSymbol);
          asmK    <= NBytes'(1);
          idx     <= IdxW'(1);
          misCnt  <= '0;
        end
      end else if (bus.SymInValid) begin
        if (isCom && idx != '0 && misCnt == 3'(LockCount - 1)) begin
          asmData <= DataWidth'(ComSymbol);
          asmK    <= NBytes'(1);
          idx     <= IdxW'(1);
          misCnt  <= '0;
          realign <= 1'b1;
        end else begin
          asmData <= nextData;
          asmK    <= nextK;
          idx     <= idx + IdxW'(1);
          if (isCom) misCnt <= (idx == '0) ? 3'd0 : misCnt + 3'd1;
          if (lastByte) begin
            pushValid <= 1'b1;
            pushWord  <= {nextK, nextData};
          end
        end
      end
    end
  end
  pcie_pipe_skid_fifo #(.Width(DataWidth + NBytes)) u_fifo (
    .pcieclk  (pcieclk),
    .reset    (reset),
    .pushValid(pushValid),
    .pushData (pushWord),
    .popReady (bus.WordOutReady),
    .headData (headWord),
    .headValid(bus.WordOutValid),
    .overflow (bus.Overflow)
  );
  assign bus.WordOut  = headWord[DataWidth-1:0];
  assign bus.WordOutK = headWord[DataWidth+NBytes-1:DataWidth];
  assign bus.Aligned  = aligned;
  assign bus.Realign  = realign;
endmodule

// File: tb/tb_pcie_pipe_symbol_packer.sv
// tb_pcie_pipe_symbol_packer: random symbol streams into 16/32/64-bit packers vs a byte-list model
module tb_pcie_pipe_symbol_packer;
  logic pcieclk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] sym = 8'h00;
  logic symK = 1'b0, symValid = 1'b0, idle = 1'b1, rdy = 1'b0;
  int checks = 0, failures = 0;
  always #5 pcieclk = ~pcieclk;

  pcie_pipe_symbol_packer_if #(.DataWidth(16)) b16 ();
  pcie_pipe_symbol_packer_if #(.DataWidth(32)) b32 ();
  pcie_pipe_symbol_packer_if #(.DataWidth(64)) b64 ();
  assign b16.SymIn = sym;  assign b16.SymInK = symK;  assign b16.SymInValid = symValid;
  assign b16.ElecIdle = idle;  assign b16.WordOutReady = rdy;
  assign b32.SymIn = sym;  assign b32.SymInK = symK;  assign b32.SymInValid = symValid;
  assign b32.ElecIdle = idle;  assign b32.WordOutReady = rdy;
  assign b64.SymIn = sym;  assign b64.SymInK = symK;  assign b64.SymInValid = symValid;
  assign b64.ElecIdle = idle;  assign b64.WordOutReady = rdy;
  pcie_pipe_symbol_packer #(.DataWidth(16)) u16 (.pcieclk(pcieclk), .reset(rst), .bus(b16));
  pcie_pipe_symbol_packer #(.DataWidth(32)) u32 (.pcieclk(pcieclk), .reset(rst), .bus(b32));
  pcie_pipe_symbol_packer #(.DataWidth(64)) u64 (.pcieclk(pcieclk), .reset(rst), .bus(b64));

  // model: lane mode, list of bytes collected so far, expected FIFO contents and flags
  localparam int LockCount = 2;
  int mode [3];
  int partLen [3];
  int misCnt [3];
  logic [7:0] partB [3][8];
  logic partK [3][8];
  bit pend [3];
  logic [63:0] pendD [3];
  logic [7:0] pendK [3];
  logic [63:0] qD [3][2];
  logic [7:0] qK [3][2];
  int qLen [3];
  bit expOv [3], expAl [3], expRe [3];

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic resetModel(input int m);
    mode[m] = 0; partLen[m] = 0; misCnt[m] = 0; pend[m] = 0; qLen[m] = 0;
    expOv[m] = 0; expAl[m] = 0; expRe[m] = 0;
  endtask

  task automatic stepModel(input int m);
    int nb;
    bit com;
    nb = 2 << m;
    if (rst) begin
      resetModel(m);
      return;
    end
    if (qLen[m] > 0 && rdy) begin
      qD[m][0] = qD[m][1]; qK[m][0] = qK[m][1];
      qLen[m]--;
    end
    if (pend[m]) begin
      if (qLen[m] < 2) begin
        qD[m][qLen[m]] = pendD[m]; qK[m][qLen[m]] = pendK[m];
        qLen[m]++;
      end else expOv[m] = 1;
    end
    pend[m] = 0;
    expRe[m] = 0;
    com = symValid && symK && sym == 8'hBC;
    if (idle) begin
      mode[m] = 0; partLen[m] = 0; misCnt[m] = 0;
    end else if (mode[m] == 0) mode[m] = 1;
    else if (mode[m] == 1) begin
      if (com) begin
        mode[m] = 2; partB[m][0] = 8'hBC; partK[m][0] = 1; partLen[m] = 1; misCnt[m] = 0;
      end
    end else if (symValid) begin
      if (com && partLen[m] != 0 && misCnt[m] + 1 == LockCount) begin
        partB[m][0] = 8'hBC; partK[m][0] = 1; partLen[m] = 1; misCnt[m] = 0; expRe[m] = 1;
      end else begin
        if (com) misCnt[m] = (partLen[m] == 0) ? 0 : misCnt[m] + 1;
        partB[m][partLen[m]] = sym; partK[m][partLen[m]] = symK;
        partLen[m]++;
        if (partLen[m] == nb) begin
          pend[m] = 1; pendD[m] = 0; pendK[m] = 0;
          for (int i = 0; i < nb; i++) begin
            pendD[m] = pendD[m] + (64'(partB[m][i]) << (8 * i));
            pendK[m] = pendK[m] + (8'(partK[m][i]) << i);
          end
          partLen[m] = 0;
        end
      end
    end
    expAl[m] = mode[m] == 2;
  endtask

  task automatic cmpDut(input int m, input logic v, input logic [63:0] d, input logic [7:0] k,
                        input logic a, input logic r, input logic o);
    string w;
    w = $sformatf("w%0d", 16 << m);
    checkEq({w, ".valid"}, 64'(v), 64'(qLen[m] > 0));
    checkEq({w, ".aligned"}, 64'(a), 64'(expAl[m]));
    checkEq({w, ".realign"}, 64'(r), 64'(expRe[m]));
    checkEq({w, ".overflow"}, 64'(o), 64'(expOv[m]));
    if (qLen[m] > 0) begin
      checkEq({w, ".word"}, d, qD[m][0]);
      checkEq({w, ".wordK"}, 64'(k), 64'(qK[m][0]));
    end
  endtask

  task automatic tick();
    @(posedge pcieclk);
    for (int m = 0; m < 3; m++) stepModel(m);
    #1;
    cmpDut(0, b16.WordOutValid, 64'(b16.WordOut), 8'(b16.WordOutK), b16.Aligned, b16.Realign, b16.Overflow);
    cmpDut(1, b32.WordOutValid, 64'(b32.WordOut), 8'(b32.WordOutK), b32.Aligned, b32.Realign, b32.Overflow);
    cmpDut(2, b64.WordOutValid, b64.WordOut, b64.WordOutK, b64.Aligned, b64.Realign, b64.Overflow);
  endtask

  task automatic sendSym(input logic [7:0] s, input logic k);
    sym = s; symK = k; symValid = 1'b1;
    tick();
    symValid = 1'b0;
  endtask

  task automatic setRand(input int pValid);
    symValid = ($urandom % 100) < pValid;
    if ($urandom % 12 == 0) begin
      sym = 8'hBC; symK = 1'b1;
    end else begin
      sym = 8'($urandom); symK = ($urandom % 8) == 0;
      if (symK && sym == 8'hBC) sym = 8'h1C;
    end
  endtask

  task automatic randPhase(input int n, input int pRdy, input int pIdle);
    for (int c = 0; c < n; c++) begin
      setRand(85);
      rdy = ($urandom % 100) < pRdy;
      if (($urandom % 1000) < pIdle) begin
        idle = 1'b1;
        repeat (1 + $urandom % 3) tick();
        idle = 1'b0;
      end
      tick();
    end
    symValid = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 3; m++) resetModel(m);
    repeat (3) tick();
    checkEq("rst.word32", 64'(b32.WordOut), 64'h0);
    checkEq("rst.wordK64", 64'(b64.WordOutK), 64'h0);
    rst = 1'b0; idle = 1'b0; rdy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) sendSym(8'h40 + 8'(i), 1'b0);
    sendSym(8'hBC, 1'b1);
    checkEq("t1.aligned", 64'(b32.Aligned), 64'h1);
    sendSym(8'h01, 1'b0);
    tick();
    sendSym(8'h02, 1'b0);
    sendSym(8'h03, 1'b0);
    checkEq("t1.notyet", 64'(b32.WordOutValid), 64'h0);
    tick();
    checkEq("t1.word32", 64'(b32.WordOut), 64'h030201BC);
    checkEq("t1.wordK32", 64'(b32.WordOutK), 64'h1);
    for (int i = 4; i < 8; i++) begin
      sendSym(8'(i), 1'b0);
      tick();
    end
    repeat (3) tick();
    checkEq("t6.word64", b64.WordOut, 64'h07060504030201BC);
    randPhase(1500, 70, 15);
    randPhase(80, 0, 0);
    rdy = 1'b1;
    repeat (10) tick();
    randPhase(60, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkEq("t7.valid", 64'(b32.WordOutValid), 64'h0);
    checkEq("t7.overflow", 64'(b64.Overflow), 64'h0);
    randPhase(1500, 60, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
